// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control
//  Purpose  : Decodes opcode/funct into an ALU mode bundle and presents it
//             through a two-entry skid buffer (output register + skid
//             register) with a valid/ready handshake on both sides.
//  Ports    : i_clk, i_rst_n       - clock (rising edge), async active-low reset
//             i_valid/o_ready      - upstream handshake
//             i_opcode, i_funct    - instruction bits [31:26] and [5:0]
//             i_flush              - drop held and incoming entries
//             o_valid/i_ready      - downstream (EX) handshake
//             o_mode, o_alu_src, o_shamt_sel, o_illegal - decoded bundle
//             o_illegal_cnt        - saturating count of accepted illegal inputs
//  Macro    : ALU_CTRL_ILLEGAL_CNT_EN enables the illegal counter; when
//             undefined o_illegal_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_control #(
    parameter int MODE_WIDTH = 6,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [OP_WIDTH-1:0]   i_opcode,
    input  logic [OP_WIDTH-1:0]   i_funct,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [MODE_WIDTH-1:0] o_mode,
    output logic                  o_alu_src,
    output logic                  o_shamt_sel,
    output logic                  o_illegal,
    output logic [7:0]            o_illegal_cnt
);

    localparam logic [5:0] c_MODE_ADD  = 6'b100000;
    localparam logic [5:0] c_MODE_ADDU = 6'b100001;
    localparam logic [5:0] c_MODE_SUBU = 6'b100011;
    localparam logic [5:0] c_MODE_AND  = 6'b100100;
    localparam logic [5:0] c_MODE_OR   = 6'b100101;
    localparam logic [5:0] c_MODE_XOR  = 6'b100110;
    localparam logic [5:0] c_MODE_SLT  = 6'b101000;
    localparam logic [5:0] c_MODE_SLTU = 6'b101001;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [5:0] w_dec_mode;
    logic       w_dec_src;
    logic       w_dec_shamt;
    logic       w_dec_illegal;

    assign w_op = 6'(i_opcode);
    assign w_fn = 6'(i_funct);

    always_comb begin
        // Undecodable inputs fall through with the ADDU mode and no side flags.
        w_dec_mode    = c_MODE_ADDU;
        w_dec_src     = 1'b0;
        w_dec_shamt   = 1'b0;
        w_dec_illegal = 1'b0;
        if (w_op == 6'b000000) begin
            casez (w_fn)
                6'b100???: w_dec_mode = w_fn;
                6'b101010: w_dec_mode = c_MODE_SLT;
                6'b101011: w_dec_mode = c_MODE_SLTU;
                6'b000000, 6'b000010, 6'b000011: begin
                    w_dec_mode  = w_fn;
                    w_dec_shamt = 1'b1;
                end
                // Variable shifts reuse the immediate-shift mode codes.
                6'b000100: w_dec_mode = 6'b000000;
                6'b000110: w_dec_mode = 6'b000010;
                6'b000111: w_dec_mode = 6'b000011;
                default:   w_dec_illegal = 1'b1;
            endcase
        end else if (w_op[5]) begin
            // Loads/stores: address = base + offset.
            w_dec_mode = c_MODE_ADDU;
            w_dec_src  = 1'b1;
        end else begin
            case (w_op)
                6'b001000: begin w_dec_mode = c_MODE_ADD;  w_dec_src = 1'b1; end
                6'b001001: begin w_dec_mode = c_MODE_ADDU; w_dec_src = 1'b1; end
                6'b001010: begin w_dec_mode = c_MODE_SLT;  w_dec_src = 1'b1; end
                6'b001011: begin w_dec_mode = c_MODE_SLTU; w_dec_src = 1'b1; end
                6'b001100: begin w_dec_mode = c_MODE_AND;  w_dec_src = 1'b1; end
                6'b001101: begin w_dec_mode = c_MODE_OR;   w_dec_src = 1'b1; end
                6'b001110: begin w_dec_mode = c_MODE_XOR;  w_dec_src = 1'b1; end
                // LUI: datapath shifts the immediate and zeroes A, so OR suffices.
                6'b001111: begin w_dec_mode = c_MODE_OR;   w_dec_src = 1'b1; end
                6'b000100, 6'b000101: w_dec_mode = c_MODE_SUBU;
                default: w_dec_illegal = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    logic       r_out_valid;
    logic [5:0] r_out_mode;
    logic       r_out_src;
    logic       r_out_shamt;
    logic       r_out_illegal;
    logic       r_skid_valid;
    logic [5:0] r_skid_mode;
    logic       r_skid_src;
    logic       r_skid_shamt;
    logic       r_skid_illegal;
    logic       w_accept;
    logic       w_out_free;

    // Ready depends only on the skid register, never on i_ready.
    assign o_ready    = ~r_skid_valid;
    assign w_accept   = i_valid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_mode     <= 6'd0;
            r_out_src      <= 1'b0;
            r_out_shamt    <= 1'b0;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_mode    <= 6'd0;
            r_skid_src     <= 1'b0;
            r_skid_shamt   <= 1'b0;
            r_skid_illegal <= 1'b0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid entry is older than anything upstream; drain it first.
                r_out_valid   <= 1'b1;
                r_out_mode    <= r_skid_mode;
                r_out_src     <= r_skid_src;
                r_out_shamt   <= r_skid_shamt;
                r_out_illegal <= r_skid_illegal;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_mode    <= w_dec_mode;
                r_out_src     <= w_dec_src;
                r_out_shamt   <= w_dec_shamt;
                r_out_illegal <= w_dec_illegal;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the new entry, output fields stay put.
            r_skid_valid   <= 1'b1;
            r_skid_mode    <= w_dec_mode;
            r_skid_src     <= w_dec_src;
            r_skid_shamt   <= w_dec_shamt;
            r_skid_illegal <= w_dec_illegal;
        end
    end

    assign o_valid     = r_out_valid;
    assign o_mode      = MODE_WIDTH'(r_out_mode);
    assign o_alu_src   = r_out_src;
    assign o_shamt_sel = r_out_shamt;
    assign o_illegal   = r_out_illegal;

    // ------------------------------------------------------------------
    // Optional saturating illegal-input counter
    // ------------------------------------------------------------------
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [7:0] r_illegal_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_illegal_cnt <= 8'd0;
        end else if (w_accept && !i_flush && w_dec_illegal && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
    end

    assign o_illegal_cnt = r_illegal_cnt;
`else
    assign o_illegal_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_control
//  Purpose  : Directed self-checking bench for alu_control.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_flush;
    logic       o_valid;
    logic       i_ready;
    logic [5:0] o_mode;
    logic       o_alu_src;
    logic       o_shamt_sel;
    logic       o_illegal;
    logic [7:0] o_illegal_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_control #(
        .MODE_WIDTH (6),
        .OP_WIDTH   (6)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_opcode      (i_opcode),
        .i_funct       (i_funct),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_mode        (o_mode),
        .o_alu_src     (o_alu_src),
        .o_shamt_sel   (o_shamt_sel),
        .o_illegal     (o_illegal),
        .o_illegal_cnt (o_illegal_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected counter value given how many illegal inputs were accepted.
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        return (n > 255) ? 32'd255 : 32'(n);
`else
        return 32'd0 + 32'(n * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle input pulse; with i_ready=1 the result is visible on return.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn);
        i_valid  = 1'b1;
        i_opcode = op;
        i_funct  = fn;
        tick();
        i_valid  = 1'b0;
    endtask

    task automatic check_bundle(input string tag, input logic [5:0] mode,
                                input logic src, input logic sh, input logic ill);
        check({tag, ".valid"}, 32'(o_valid), 32'd1);
        check({tag, ".mode"},  32'(o_mode), 32'(mode));
        check({tag, ".src"},   32'(o_alu_src), 32'(src));
        check({tag, ".shamt"}, 32'(o_shamt_sel), 32'(sh));
        check({tag, ".ill"},   32'(o_illegal), 32'(ill));
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_opcode = 6'd0;
        i_funct  = 6'd0;
        i_flush  = 1'b0;
        i_ready  = 1'b1;
        #12;
        check("rst.valid", 32'(o_valid), 32'd0);
        check("rst.ready", 32'(o_ready), 32'd1);
        check("rst.mode",  32'(o_mode), 32'd0);
        check("rst.cnt",   32'(o_illegal_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Decode vectors, i_ready held high
        drive(6'b000000, 6'b101010); check_bundle("slt",  6'b101000, 1'b0, 1'b0, 1'b0);
        drive(6'b001101, 6'b000000); check_bundle("ori",  6'b100101, 1'b1, 1'b0, 1'b0);
        drive(6'b100011, 6'b000000); check_bundle("lw",   6'b100001, 1'b1, 1'b0, 1'b0);
        drive(6'b000000, 6'b000011); check_bundle("sra",  6'b000011, 1'b0, 1'b1, 1'b0);
        drive(6'b000000, 6'b000110); check_bundle("srlv", 6'b000010, 1'b0, 1'b0, 1'b0);
        drive(6'b001111, 6'b000000); check_bundle("lui",  6'b100101, 1'b1, 1'b0, 1'b0);
        drive(6'b000101, 6'b000000); check_bundle("bne",  6'b100011, 1'b0, 1'b0, 1'b0);
        drive(6'b000000, 6'b001000); check_bundle("jr",   6'b100001, 1'b0, 1'b0, 1'b1);
        check("cnt.one", 32'(o_illegal_cnt), exp_cnt(1));
        tick();
        check("drain.valid", 32'(o_valid), 32'd0);

        // Flush with an accepted illegal input: discarded and not counted
        i_flush = 1'b1;
        drive(6'b010000, 6'b000000);
        i_flush = 1'b0;
        check("flacc.valid", 32'(o_valid), 32'd0);
        check("flacc.cnt",   32'(o_illegal_cnt), exp_cnt(1));

        // Stall: ADDI held, ANDI skidded, BEQ blocked
        i_ready = 1'b0;
        drive(6'b001000, 6'b000000);
        drive(6'b001100, 6'b000000);
        check("stall.ready", 32'(o_ready), 32'd0);
        check("stall.mode",  32'(o_mode), 32'(6'b100000));
        i_valid  = 1'b1;
        i_opcode = 6'b000100;
        tick();
        check("stall.hold.mode",  32'(o_mode), 32'(6'b100000));
        check("stall.hold.ready", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        tick();
        check("order.2", 32'(o_mode), 32'(6'b100100));
        check("order.2.ready", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        check_bundle("order.3", 6'b100011, 1'b0, 1'b0, 1'b0);
        tick();
        check("order.end", 32'(o_valid), 32'd0);

        // Flush with both entries full and i_valid high
        i_ready = 1'b0;
        drive(6'b001000, 6'b000000);
        drive(6'b001100, 6'b000000);
        i_flush  = 1'b1;
        i_valid  = 1'b1;
        i_opcode = 6'b001110;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush.valid", 32'(o_valid), 32'd0);
        check("flush.ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        tick();
        tick();
        check("flush.after", 32'(o_valid), 32'd0);

        // Saturating counter: 300 illegal inputs on top of the earlier one
        i_valid  = 1'b1;
        i_opcode = 6'b010000;
        repeat (253) tick();
        check("cnt.254", 32'(o_illegal_cnt), exp_cnt(254));
        tick();
        check("cnt.255", 32'(o_illegal_cnt), exp_cnt(255));
        repeat (46) tick();
        i_valid = 1'b0;
        check("cnt.sat", 32'(o_illegal_cnt), exp_cnt(301));

        // Asynchronous reset mid-stall
        i_ready = 1'b0;
        drive(6'b001000, 6'b000000);
        drive(6'b001100, 6'b000000);
        check("prerst.ready", 32'(o_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(o_valid), 32'd0);
        check("arst.ready", 32'(o_ready), 32'd1);
        check("arst.mode",  32'(o_mode), 32'd0);
        check("arst.cnt",   32'(o_illegal_cnt), 32'd0);
        #3 rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        drive(6'b001101, 6'b000000); check_bundle("postrst", 6'b100101, 1'b1, 1'b0, 1'b0);
        tick();
        check("postrst.drain", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MODE_WIDTH, 6, width of emitted ALU mode code.
- OP_WIDTH, 6, width of opcode and funct fields.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, sole clock, rising edge.
- i_rst_n, in, 1, reset, asynchronous, active-low.
- i_valid, in, 1, upstream decoded-instruction valid.
- o_ready, out, 1, block can accept input.
- i_opcode, in, OP_WIDTH, instruction bits [31:26].
- i_funct, in, OP_WIDTH, instruction bits [5:0].
- i_flush, in, 1, discard all held and incoming entries.
- o_valid, out, 1, output bundle valid.
- i_ready, in, 1, EX stage accepts bundle.
- o_mode, out, MODE_WIDTH, ALU mode code.
- o_alu_src, out, 1, 1 = ALU B operand is the immediate.
- o_shamt_sel, out, 1, 1 = shift amount taken from shamt field.
- o_illegal, out, 1, opcode/funct not decodable.
- o_illegal_cnt, out, 8, saturating illegal count (macro-dependent).
REQ-003 Clock and reset SHALL be one clock, i_clk; reset i_rst_n is asynchronous and active-low.

Function
REQ-004 Decode, R-type (opcode 000000), SHALL map funct to mode:
- 100000..100111 -> same code.
- 101010 -> 101000 (SLT); 101011 -> 101001 (SLTU).
- 000000/000010/000011 -> same code, o_shamt_sel=1.
- 000100 -> 000000, 000110 -> 000010, 000111 -> 000011, o_shamt_sel=0.
- Any other funct -> illegal.
REQ-005 Decode, I-type, SHALL set o_alu_src=1 and map:
- ADDI 001000 -> 100000; ADDIU 001001 -> 100001.
- SLTI 001010 -> 101000; SLTIU 001011 -> 101001.
- ANDI 001100 -> 100100; ORI 001101 -> 100101; XORI 001110 -> 100110.
- LUI 001111 -> 100101 (datapath supplies {imm,16'b0} and A=0).
- Any opcode with bit 5 = 1 (load/store) -> 100001.
REQ-006 Branches BEQ 000100 and BNE 000101 SHALL map to 100011 with o_alu_src=0.
REQ-007 Any undecoded input SHALL give o_illegal=1, o_mode=100001, o_alu_src=0, o_shamt_sel=0.
REQ-008 An input SHALL be accepted on a rising edge where i_valid and o_ready are both 1. An output SHALL be consumed on a rising edge where o_valid and i_ready are both 1.
REQ-009 Buffering SHALL be a two-entry skid buffer: an output register plus one skid register.
REQ-010 Latency SHALL be 1 cycle: an input accepted while the output register is empty or being consumed appears on o_* on the next cycle.
REQ-011 An input accepted while the output is valid and i_ready=0 SHALL go to the skid register.
REQ-012 When the output register frees, the skid entry SHALL move into it before any new input, preserving order.
REQ-013 o_ready SHALL equal NOT skid-valid and SHALL NOT depend combinationally on i_ready.
REQ-014 Output bundle fields SHALL hold stable while o_valid=1 and i_ready=0.
REQ-015 i_flush=1 SHALL have priority over all other events:
- both entries are invalidated on the next edge;
- an input accepted in the same cycle is discarded and not counted.

Reset
REQ-016 On i_rst_n low, the block SHALL immediately clear:
- o_valid=0, skid-valid=0, o_ready=1;
- o_mode=0, o_alu_src=0, o_shamt_sel=0, o_illegal=0, o_illegal_cnt=0.
REQ-017 Entries in flight when reset asserts SHALL be lost. The first accept after release SHALL behave as from an empty buffer.

Configuration
REQ-018 With ALU_CTRL_ILLEGAL_CNT_EN defined, o_illegal_cnt SHALL:
- increment by 1 for each accepted, non-flushed illegal input;
- saturate at 255.
REQ-019 Without ALU_CTRL_ILLEGAL_CNT_EN, o_illegal_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- R-type funct 101010, i_ready=1 -> next cycle o_valid=1, o_mode=101000, o_alu_src=0.
- Opcode 001101 (ORI) -> o_mode=100101, o_alu_src=1. Opcode 100011 (LW) -> o_mode=100001, o_alu_src=1.
- i_ready=0, then 3 back-to-back inputs (ADDI, ANDI, BEQ) -> ADDI held, ANDI in skid, o_ready=0, BEQ not accepted. Raise i_ready -> 100000, 100100, then 100011 in order.
- i_flush with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1, nothing later emitted.
- Macro defined: 300 illegal inputs (opcode 111111 excluded; use opcode 010000) -> o_illegal_cnt=255. Macro undefined -> stays 0.
- i_rst_n pulsed low mid-stall -> o_valid=0 and o_ready=1 before the next clock edge.
